// File: rtl/dma_cmd_pkg.sv
// Shared types for the DMA command queue: descriptor layout and sequencer states.
package dma_cmd_pkg;

   localparam int ADDR_BITS      = 8;
   localparam int SRAM_ADDR_BITS = 11;
   localparam int LEN_BITS       = 8;
   localparam int TAG_BITS       = 2;

   typedef struct packed {
      logic                      direction;
      logic [ADDR_BITS-1:0]      ext_addr;
      logic [SRAM_ADDR_BITS-1:0] sram_addr;
      logic [LEN_BITS-1:0]       length;
      logic [TAG_BITS-1:0]       tag;
   } desc_t;

   localparam int DESC_BITS = $bits(desc_t);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      CPL
   } state_e;

endpackage

// File: rtl/dma_cmd_queue_desc_fifo.sv
// Generic synchronous FIFO with head peek and a flush that can keep the head.
module desc_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wdata,
   input  logic                       pop,
   input  logic                       flush,
   input  logic                       keep_head,
   output logic [WIDTH-1:0]           rdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_q, rd_d;
   logic [PW-1:0]    wr_q, wr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             we;
   logic             kept;

   assign we = push && !flush;

   always_comb begin
      rd_d    = rd_q + PW'(pop);
      wr_d    = wr_q;
      count_d = count_q;
      kept    = 1'b0;
      if (flush) begin
         // A kept head that is popped in the same cycle leaves nothing behind.
         kept    = keep_head && !pop;
         wr_d    = rd_d + PW'(kept);
         count_d = CW'(kept);
      end else begin
         wr_d    = wr_q + PW'(we);
         count_d = count_q + CW'(we) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[wr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_q];
   assign count = count_q;
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);

endmodule

// File: rtl/dma_cmd_queue.sv
// Descriptor queue and sequencer feeding the DMA engine one command at a time.
module dma_cmd_queue
   import dma_cmd_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enq_valid,
   output logic                       enq_ready,
   input  logic                       enq_direction,
   input  logic [ADDR_BITS-1:0]       enq_ext_addr,
   input  logic [SRAM_ADDR_BITS-1:0]  enq_sram_addr,
   input  logic [LEN_BITS-1:0]        enq_length,
   input  logic [TAG_BITS-1:0]        enq_tag,
   input  logic                       flush,
   output logic                       cmd_valid,
   input  logic                       cmd_ready,
   output logic                       cmd_direction,
   output logic [ADDR_BITS-1:0]       cmd_ext_addr,
   output logic [SRAM_ADDR_BITS-1:0]  cmd_sram_addr,
   output logic [LEN_BITS-1:0]        cmd_length,
   input  logic                       cmd_done,
   input  logic                       cmd_error,
   output logic                       cpl_valid,
   output logic [TAG_BITS-1:0]        cpl_tag,
   output logic                       cpl_error,
   output logic [$clog2(DEPTH+1)-1:0] queue_count,
   output logic                       idle
);

   localparam int CW = $clog2(DEPTH+1);

   state_e        state_q, state_d;
   logic          err_q, err_d;
   desc_t         enq_desc;
   desc_t         head;
   logic          push, pop, keep_head;
   logic          issue;
   logic          fifo_full, fifo_empty;
   logic [CW-1:0] count;

   assign enq_desc = '{
      direction: enq_direction,
      ext_addr:  enq_ext_addr,
      sram_addr: enq_sram_addr,
      length:    enq_length,
      tag:       enq_tag
   };

   assign enq_ready = !fifo_full;
   assign push      = enq_valid && enq_ready && !flush;

   desc_fifo #(
      .WIDTH (DESC_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (reset),
      .push      (push),
      .wdata     (enq_desc),
      .pop       (pop),
      .flush     (flush),
      .keep_head (keep_head),
      .rdata     (head),
      .count     (count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      pop       = 1'b0;
      keep_head = 1'b0;
      issue     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!flush && (!fifo_empty || push)) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (flush) begin
               state_d = IDLE;
            end else if (head.length == '0) begin
               // Zero-length work is completed as an error without touching the engine.
               state_d = CPL;
               err_d   = 1'b1;
            end else begin
               issue = 1'b1;
               if (cmd_ready) begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            keep_head = 1'b1;
            if (cmd_error) begin
               state_d = CPL;
               err_d   = 1'b1;
            end else if (cmd_done) begin
               state_d = CPL;
               err_d   = 1'b0;
            end
         end
         CPL: begin
            keep_head = 1'b1;
            pop       = 1'b1;
            // Chain straight into the next issue when work remains.
            if (!flush && (count > CW'(1) || push)) begin
               state_d = ISSUE;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
      end
   end

   assign cmd_valid     = issue;
   assign cmd_direction = issue & head.direction;
   assign cmd_ext_addr  = issue ? head.ext_addr : '0;
   assign cmd_sram_addr = issue ? head.sram_addr : '0;
   assign cmd_length    = issue ? head.length : '0;

   assign cpl_valid = (state_q == CPL);
   assign cpl_tag   = cpl_valid ? head.tag : '0;
   assign cpl_error = cpl_valid & err_q;

   assign queue_count = count;
   assign idle        = (state_q == IDLE) && fifo_empty;

endmodule

// File: tb/tb_dma_cmd_queue.sv
// Directed self-checking bench for dma_cmd_queue.
module tb_dma_cmd_queue;

   logic        clk;
   logic        reset;
   logic        enq_valid;
   logic        enq_ready;
   logic        enq_direction;
   logic [7:0]  enq_ext_addr;
   logic [10:0] enq_sram_addr;
   logic [7:0]  enq_length;
   logic [1:0]  enq_tag;
   logic        flush;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_direction;
   logic [7:0]  cmd_ext_addr;
   logic [10:0] cmd_sram_addr;
   logic [7:0]  cmd_length;
   logic        cmd_done;
   logic        cmd_error;
   logic        cpl_valid;
   logic [1:0]  cpl_tag;
   logic        cpl_error;
   logic [2:0]  queue_count;
   logic        idle;

   int n_chk = 0;
   int n_err = 0;

   dma_cmd_queue #(.DEPTH(4)) dut (
      .clk           (clk),
      .reset         (reset),
      .enq_valid     (enq_valid),
      .enq_ready     (enq_ready),
      .enq_direction (enq_direction),
      .enq_ext_addr  (enq_ext_addr),
      .enq_sram_addr (enq_sram_addr),
      .enq_length    (enq_length),
      .enq_tag       (enq_tag),
      .flush         (flush),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_direction (cmd_direction),
      .cmd_ext_addr  (cmd_ext_addr),
      .cmd_sram_addr (cmd_sram_addr),
      .cmd_length    (cmd_length),
      .cmd_done      (cmd_done),
      .cmd_error     (cmd_error),
      .cpl_valid     (cpl_valid),
      .cpl_tag       (cpl_tag),
      .cpl_error     (cpl_error),
      .queue_count   (queue_count),
      .idle          (idle)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic drive_desc(input logic d, input logic [7:0] e,
                             input logic [10:0] s, input logic [7:0] l,
                             input logic [1:0] t);
      enq_direction = d;
      enq_ext_addr  = e;
      enq_sram_addr = s;
      enq_length    = l;
      enq_tag       = t;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL rst_enq_ready: got %b want 1", enq_ready); end
      n_chk++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", idle); end
      n_chk++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL rst_cmd_valid: got %b want 0", cmd_valid); end
      n_chk++; if (cpl_valid !== 1'b0) begin n_err++; $display("FAIL rst_cpl_valid: got %b want 0", cpl_valid); end
      n_chk++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", queue_count); end
      n_chk++; if (cmd_ext_addr !== 8'h00) begin n_err++; $display("FAIL rst_ext_addr: got %h want 00", cmd_ext_addr); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int nv = 0;
      int nc = 0;
      int vcyc = -1;
      int ccyc = -1;
      logic [1:0] ctag = 2'd0;
      logic cerr = 1'b1;
      drive_desc(1'b0, 8'h10, 11'h040, 8'd8, 2'd1);
      enq_valid = 1'b1;
      cmd_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (enq_ready !== 1'b1) begin n_err++; $display("FAIL single_enq_ready: got %b want 1", enq_ready); end
      @(posedge clk); #1;
      enq_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cmd_done = (i == 5);
         @(negedge clk);
         if (cmd_valid) begin
            nv++;
            vcyc = i;
            n_chk++; if ({cmd_direction, cmd_ext_addr, cmd_sram_addr, cmd_length} !== {1'b0, 8'h10, 11'h040, 8'd8}) begin
               n_err++; $display("FAIL single_fields: got %b/%h/%h/%0d want 0/10/040/8", cmd_direction, cmd_ext_addr, cmd_sram_addr, cmd_length);
            end
         end
         if (cpl_valid) begin
            nc++;
            ccyc = i;
            ctag = cpl_tag;
            cerr = cpl_error;
         end
         @(posedge clk); #1;
      end
      cmd_done = 1'b0;
      n_chk++; if (nv !== 1) begin n_err++; $display("FAIL single_nvalid: got %0d want 1", nv); end
      n_chk++; if (vcyc !== 0) begin n_err++; $display("FAIL single_valid_cycle: got %0d want 0", vcyc); end
      n_chk++; if (nc !== 1) begin n_err++; $display("FAIL single_ncpl: got %0d want 1", nc); end
      n_chk++; if (ccyc !== 6) begin n_err++; $display("FAIL single_cpl_cycle: got %0d want 6", ccyc); end
      n_chk++; if (ctag !== 2'd1) begin n_err++; $display("FAIL single_cpl_tag: got %0d want 1", ctag); end
      n_chk++; if (cerr !== 1'b0) begin n_err++; $display("FAIL single_cpl_error: got %b want 0", cerr); end
      n_chk++; if (idle !== 1'b1) begin n_err++; $display("FAIL single_idle: got %b want 1", idle); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] tg [5];
      logic [1:0] got [5];
      int k = 0;
      int nc = 0;
      int i = 0;
      int done_at = -1;
      int d0 = -1;
      int c0 = -1;
      int iss1 = -1;
      int acc5 = -1;
      int nis = 0;
      logic pv = 1'b0;
      logic seen_full = 1'b0;
      tg = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      got = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
      cmd_ready = 1'b1;
      while (nc < 5 && i < 100) begin
         enq_valid = (k < 5);
         if (k < 5) drive_desc(k[0], 8'h20 + 8'(k), 11'h100 + 11'(k), 8'd4, tg[k]);
         cmd_done = (i == done_at);
         if (cmd_done && d0 < 0) d0 = i;
         @(negedge clk);
         if (k == 4 && !seen_full) begin
            seen_full = 1'b1;
            n_chk++; if (enq_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %b want 0", enq_ready); end
            n_chk++; if (queue_count !== 3'd4) begin n_err++; $display("FAIL b2b_full_count: got %0d want 4", queue_count); end
         end
         if (cmd_valid && !pv) begin
            nis++;
            if (nis == 2) iss1 = i;
         end
         pv = cmd_valid;
         if (cmd_valid && cmd_ready) done_at = i + 2;
         if (cpl_valid) begin
            got[nc] = cpl_tag;
            n_chk++; if (cpl_error !== 1'b0) begin n_err++; $display("FAIL b2b_cpl_error: got %b want 0", cpl_error); end
            if (nc == 0) c0 = i;
            nc++;
         end
         if (enq_valid && enq_ready) begin
            if (k == 4) acc5 = i;
            k++;
         end
         @(posedge clk); #1;
         i++;
      end
      enq_valid = 1'b0;
      cmd_done = 1'b0;
      n_chk++; if (nc !== 5) begin n_err++; $display("FAIL b2b_ncpl: got %0d want 5", nc); end
      for (int j = 0; j < 5; j++) begin
         n_chk++; if (got[j] !== tg[j]) begin n_err++; $display("FAIL b2b_tag_order[%0d]: got %0d want %0d", j, got[j], tg[j]); end
      end
      n_chk++; if (c0 !== d0 + 1) begin n_err++; $display("FAIL b2b_cpl_latency: got %0d want %0d", c0, d0 + 1); end
      n_chk++; if (iss1 !== d0 + 2) begin n_err++; $display("FAIL b2b_next_issue: got %0d want %0d", iss1, d0 + 2); end
      n_chk++; if (acc5 !== c0 + 1) begin n_err++; $display("FAIL b2b_fifth_accept: got %0d want %0d", acc5, c0 + 1); end
      n_chk++; if (idle !== 1'b1) begin n_err++; $display("FAIL b2b_idle: got %b want 1", idle); end
   endtask

   task automatic test_stall();
      drive_desc(1'b1, 8'h33, 11'h155, 8'd3, 2'd1);
      enq_valid = 1'b1;
      cmd_ready = 1'b0;
      @(posedge clk); #1;
      enq_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cmd_ready = (i == 3);
         @(negedge clk);
         n_chk++; if (cmd_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b want 1", i, cmd_valid); end
         n_chk++; if ({cmd_direction, cmd_ext_addr, cmd_sram_addr, cmd_length} !== {1'b1, 8'h33, 11'h155, 8'd3}) begin
            n_err++; $display("FAIL stall_fields[%0d]: got %b/%h/%h/%0d want 1/33/155/3", i, cmd_direction, cmd_ext_addr, cmd_sram_addr, cmd_length);
         end
         @(posedge clk); #1;
      end
      cmd_ready = 1'b0;
      @(negedge clk);
      n_chk++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL stall_after_accept: got %b want 0", cmd_valid); end
      @(posedge clk); #1;
      cmd_done = 1'b1;
      @(posedge clk); #1;
      cmd_done = 1'b0;
      @(negedge clk);
      n_chk++; if ({cpl_valid, cpl_tag, cpl_error} !== {1'b1, 2'd1, 1'b0}) begin
         n_err++; $display("FAIL stall_cpl: got %b/%0d/%b want 1/1/0", cpl_valid, cpl_tag, cpl_error);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_zero_len();
      cmd_ready = 1'b1;
      drive_desc(1'b0, 8'h40, 11'h010, 8'd0, 2'd2);
      enq_valid = 1'b1;
      @(posedge clk); #1;
      drive_desc(1'b1, 8'h41, 11'h011, 8'd5, 2'd3);
      @(negedge clk);
      n_chk++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL zlen_no_issue: got %b want 0", cmd_valid); end
      @(posedge clk); #1;
      enq_valid = 1'b0;
      @(negedge clk);
      n_chk++; if ({cpl_valid, cpl_tag, cpl_error} !== {1'b1, 2'd2, 1'b1}) begin
         n_err++; $display("FAIL zlen_cpl: got %b/%0d/%b want 1/2/1", cpl_valid, cpl_tag, cpl_error);
      end
      n_chk++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL zlen_cpl_no_issue: got %b want 0", cmd_valid); end
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++; if ({cmd_valid, cmd_ext_addr, cmd_length} !== {1'b1, 8'h41, 8'd5}) begin
         n_err++; $display("FAIL zlen_next_issue: got %b/%h/%0d want 1/41/5", cmd_valid, cmd_ext_addr, cmd_length);
      end
      @(posedge clk); #1;
      cmd_done = 1'b1;
      @(posedge clk); #1;
      cmd_done = 1'b0;
      @(negedge clk);
      n_chk++; if ({cpl_valid, cpl_tag, cpl_error} !== {1'b1, 2'd3, 1'b0}) begin
         n_err++; $display("FAIL zlen_next_cpl: got %b/%0d/%b want 1/3/0", cpl_valid, cpl_tag, cpl_error);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_error_flush();
      cmd_ready = 1'b1;
      drive_desc(1'b0, 8'h50, 11'h020, 8'd2, 2'd3);
      enq_valid = 1'b1;
      @(posedge clk); #1;
      drive_desc(1'b1, 8'h51, 11'h021, 8'd2, 2'd0);
      @(negedge clk);
      n_chk++; if ({cmd_valid, cmd_ext_addr} !== {1'b1, 8'h50}) begin
         n_err++; $display("FAIL err_issue: got %b/%h want 1/50", cmd_valid, cmd_ext_addr);
      end
      @(posedge clk); #1;
      drive_desc(1'b0, 8'h52, 11'h022, 8'd2, 2'd1);
      @(posedge clk); #1;
      enq_valid = 1'b0;
      flush = 1'b1;
      @(negedge clk);
      n_chk++; if (queue_count !== 3'd3) begin n_err++; $display("FAIL err_count_pre: got %0d want 3", queue_count); end
      @(posedge clk); #1;
      flush = 1'b0;
      cmd_error = 1'b1;
      @(negedge clk);
      n_chk++; if (queue_count !== 3'd1) begin n_err++; $display("FAIL err_count_flushed: got %0d want 1", queue_count); end
      @(posedge clk); #1;
      cmd_error = 1'b0;
      @(negedge clk);
      n_chk++; if ({cpl_valid, cpl_tag, cpl_error} !== {1'b1, 2'd3, 1'b1}) begin
         n_err++; $display("FAIL err_cpl: got %b/%0d/%b want 1/3/1", cpl_valid, cpl_tag, cpl_error);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++; if ({queue_count, idle, cmd_valid} !== {3'd0, 1'b1, 1'b0}) begin
         n_err++; $display("FAIL err_drained: got %0d/%b/%b want 0/1/0", queue_count, idle, cmd_valid);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_chk++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL err_no_reissue: got %b want 0", cmd_valid); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush_issue();
      int ncpl = 0;
      int nval = 0;
      cmd_ready = 1'b0;
      drive_desc(1'b0, 8'h60, 11'h030, 8'd1, 2'd1);
      enq_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b1;
      drive_desc(1'b0, 8'h61, 11'h031, 8'd1, 2'd2);
      @(negedge clk);
      n_chk++; if (cmd_valid !== 1'b0) begin n_err++; $display("FAIL fli_valid: got %b want 0", cmd_valid); end
      @(posedge clk); #1;
      flush = 1'b0;
      enq_valid = 1'b0;
      @(negedge clk);
      n_chk++; if ({queue_count, idle} !== {3'd0, 1'b1}) begin
         n_err++; $display("FAIL fli_drained: got %0d/%b want 0/1", queue_count, idle);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         if (cpl_valid) ncpl++;
         if (cmd_valid) nval++;
      end
      n_chk++; if (ncpl !== 0) begin n_err++; $display("FAIL fli_no_cpl: got %0d want 0", ncpl); end
      n_chk++; if (nval !== 0) begin n_err++; $display("FAIL fli_no_issue: got %0d want 0", nval); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      int ncpl = 0;
      cmd_ready = 1'b1;
      enq_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_desc(1'b0, 8'h70 + 8'(i), 11'h040, 8'd4, 2'(i));
         @(posedge clk); #1;
      end
      enq_valid = 1'b0;
      @(negedge clk);
      n_chk++; if (queue_count !== 3'd3) begin n_err++; $display("FAIL rmid_count_pre: got %0d want 3", queue_count); end
      @(posedge clk);
      reset = 1'b1;
      cmd_done = 1'b1;
      #1;
      n_chk++; if ({queue_count, idle, enq_ready, cmd_valid, cpl_valid} !== {3'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL rmid_reset_outputs: got %0d/%b/%b/%b/%b want 0/1/1/0/0", queue_count, idle, enq_ready, cmd_valid, cpl_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         cmd_done = 1'b0;
         @(negedge clk);
         if (cpl_valid) ncpl++;
      end
      n_chk++; if (ncpl !== 0) begin n_err++; $display("FAIL rmid_no_cpl: got %0d want 0", ncpl); end
      n_chk++; if (queue_count !== 3'd0) begin n_err++; $display("FAIL rmid_count_post: got %0d want 0", queue_count); end
      @(posedge clk); #1;
   endtask

   initial begin
      reset     = 1'b1;
      enq_valid = 1'b0;
      flush     = 1'b0;
      cmd_ready = 1'b0;
      cmd_done  = 1'b0;
      cmd_error = 1'b0;
      drive_desc(1'b0, 8'h00, 11'h000, 8'd0, 2'd0);
      test_reset();
      test_single();
      test_back_to_back();
      test_stall();
      test_zero_len();
      test_error_flush();
      test_flush_issue();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule
